// File: rtl/vga_timing.sv
// Raster timing generator: pixel/line counters plus registered sync,
// blanking and line/frame strobes aligned with the counters they decode.
module vga_timing #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 48,
  parameter int unsigned H_SYNC   = 112,
  parameter int unsigned H_BP     = 248,
  parameter int unsigned V_ACTIVE = 1024,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BP     = 38,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  output logic [11:0] hcounter,
  output logic [10:0] vcounter,
  output logic        hsync,
  output logic        vsync,
  output logic        visible,
  output logic        line_start,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 4096 || H_TOTAL < 2) begin : g_h_chk
    $error("vga_timing: H_TOTAL does not fit a 12-bit counter");
  end
  if (V_TOTAL > 2048 || V_TOTAL < 1) begin : g_v_chk
    $error("vga_timing: V_TOTAL does not fit an 11-bit counter");
  end

  // One extra bit so window ends equal to the total never wrap.
  localparam logic [12:0] H_LAST = 13'(H_TOTAL - 1);
  localparam logic [12:0] H_VIS  = 13'(H_ACTIVE);
  localparam logic [12:0] HS_LO  = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_HI  = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] V_VIS  = 12'(V_ACTIVE);
  localparam logic [11:0] VS_LO  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_HI  = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        visible_q, visible_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic        h_wrap, v_wrap;
  logic [12:0] h_ext;
  logic [11:0] v_ext;

  always_comb begin
    h_wrap = ({1'b0, hcnt_q} == H_LAST);
    v_wrap = ({1'b0, vcnt_q} == V_LAST);
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    fcnt_d = fcnt_q;
    if (pix_en) begin
      if (h_wrap) begin
        hcnt_d = '0;
        if (v_wrap) begin
          vcnt_d = '0;
          fcnt_d = fcnt_q + 8'd1;
        end else begin
          vcnt_d = vcnt_q + 11'd1;
        end
      end else begin
        hcnt_d = hcnt_q + 12'd1;
      end
    end
    // Decode from next counters so outputs line up with them.
    h_ext = {1'b0, hcnt_d};
    v_ext = {1'b0, vcnt_d};
    hsync_d = (h_ext >= HS_LO && h_ext < HS_HI) ? SYNC_POL : ~SYNC_POL;
    vsync_d = (v_ext >= VS_LO && v_ext < VS_HI) ? SYNC_POL : ~SYNC_POL;
    visible_d = (h_ext < H_VIS) && (v_ext < V_VIS);
    line_start_d = pix_en && h_wrap;
    frame_start_d = pix_en && h_wrap && v_wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      fcnt_q        <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      visible_q     <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      fcnt_q        <= fcnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      visible_q     <= visible_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcounter    = hcnt_q;
  assign vcounter    = vcnt_q;
  assign frame_cnt   = fcnt_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign visible     = visible_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
